// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default array geometry, load-select codes and feeder FSM states.
package tpu_pkg;

  localparam int ARRAY_SIZE = 4;
  localparam int DATA_W     = 32;

  localparam logic LD_SEL_A = 1'b0;
  localparam logic LD_SEL_B = 1'b1;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_STREAM,
    FS_DONE
  } feeder_state_t;

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed operand lane: registers element (step - LANE) of its vector, or zero when out of range.
module systolic_skew_lane #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int LANE   = 0,
  parameter int CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CW-1:0]         step,
  input  logic [N*DATA_W-1:0]   elems,
  output logic [DATA_W-1:0]     data,
  output logic                  valid
);

  logic [DATA_W-1:0] sel;
  logic              hit;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int e = 0; e < N; e++) begin
      if (en && (int'(step) - LANE == e)) begin
        sel = elems[e*DATA_W +: DATA_W];
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= sel;
      valid <= hit;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Tile buffer and skewed streamer feeding the systolic array's in_a/in_b lanes.
module systolic_feeder import tpu_pkg::*; #(
  parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
  parameter int DATA_W     = tpu_pkg::DATA_W,
  localparam int N  = ARRAY_SIZE,
  localparam int IW = $clog2(ARRAY_SIZE),
  localparam int CW = $clog2(2*ARRAY_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_en,
  input  logic                ld_sel,
  input  logic [IW-1:0]       ld_idx,
  input  logic [N*DATA_W-1:0] ld_data,
  output logic                ld_ready,
  input  logic                start,
  output logic                busy,
  output logic [N*DATA_W-1:0] a_data,
  output logic [N-1:0]        a_valid,
  output logic [N*DATA_W-1:0] b_data,
  output logic [N-1:0]        b_valid,
  output logic                done
);

  feeder_state_t     state, state_nxt;
  logic [CW-1:0]     step, step_nxt;
  logic [DATA_W-1:0] tile_a     [N][N];
  logic [DATA_W-1:0] tile_b     [N][N];
  logic [DATA_W-1:0] tile_a_nxt [N][N];
  logic [DATA_W-1:0] tile_b_nxt [N][N];
  logic [N*DATA_W-1:0] a_vec [N];
  logic [N*DATA_W-1:0] b_vec [N];
  logic wr;
  logic stream_nxt;

  assign wr         = ld_en && (state == FS_IDLE) && (int'(ld_idx) < N);
  assign stream_nxt = (state_nxt == FS_STREAM);
  assign ld_ready   = !busy;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      FS_IDLE: begin
        if (start) begin
          state_nxt = FS_STREAM;
          step_nxt  = '0;
        end
      end
      FS_STREAM: begin
        if (step == CW'(2*N-2)) begin
          state_nxt = FS_DONE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + CW'(1);
        end
      end
      FS_DONE: state_nxt = FS_IDLE;
      default: state_nxt = FS_IDLE;
    endcase
  end

  // Lanes select from the post-write tile so a same-cycle load and start stream the new row.
  always_comb begin
    tile_a_nxt = tile_a;
    tile_b_nxt = tile_b;
    for (int e = 0; e < N; e++) begin
      if (wr && ld_sel == LD_SEL_A) tile_a_nxt[ld_idx][e] = ld_data[e*DATA_W +: DATA_W];
      if (wr && ld_sel == LD_SEL_B) tile_b_nxt[ld_idx][e] = ld_data[e*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    a_vec = '{default: '0};
    b_vec = '{default: '0};
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < N; k++) begin
        a_vec[l][k*DATA_W +: DATA_W] = tile_a_nxt[l][k];
        b_vec[l][k*DATA_W +: DATA_W] = tile_b_nxt[k][l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FS_IDLE;
      step   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tile_a <= '{default: '0};
      tile_b <= '{default: '0};
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      busy   <= stream_nxt;
      done   <= (state_nxt == FS_DONE);
      tile_a <= tile_a_nxt;
      tile_b <= tile_b_nxt;
    end
  end

  for (genvar l = 0; l < N; l++) begin : g_lane
    systolic_skew_lane #(.N(N), .DATA_W(DATA_W), .LANE(l), .CW(CW)) u_a (
      .clk   (clk),
      .rst   (rst),
      .en    (stream_nxt),
      .step  (step_nxt),
      .elems (a_vec[l]),
      .data  (a_data[l*DATA_W +: DATA_W]),
      .valid (a_valid[l])
    );
    systolic_skew_lane #(.N(N), .DATA_W(DATA_W), .LANE(l), .CW(CW)) u_b (
      .clk   (clk),
      .rst   (rst),
      .en    (stream_nxt),
      .step  (step_nxt),
      .elems (b_vec[l]),
      .data  (b_data[l*DATA_W +: DATA_W]),
      .valid (b_valid[l])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with N=4, DATA_W=32.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst, ld_en, ld_sel, start;
  logic [1:0]     ld_idx;
  logic [N*DW-1:0] ld_data;
  logic           ld_ready, busy, done;
  logic [N*DW-1:0] a_data, b_data;
  logic [N-1:0]   a_valid, b_valid;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];

  systolic_feeder #(.ARRAY_SIZE(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx),
    .ld_data(ld_data), .ld_ready(ld_ready), .start(start), .busy(busy),
    .a_data(a_data), .a_valid(a_valid), .b_data(b_data), .b_valid(b_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic sel, input int idx, input logic [N*DW-1:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_idx = 2'(idx); ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", tag, done, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({busy, done, a_valid, b_valid} !== '0 || a_data !== '0 || b_data !== '0 || ld_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b av=%b bv=%b ad=%h bd=%h rdy=%b, required all 0 and rdy=1",
                 i, busy, done, a_valid, b_valid, a_data, b_data, ld_ready);
      end
    end
  endtask

  task automatic load_tiles();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        ma[i][k] = DW'(16*i + k);
        d[k*DW +: DW] = ma[i][k];
      end
      load_row(1'b0, i, d);
    end
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        mb[k][j] = DW'(32'h100 + 16*k + j);
        d[j*DW +: DW] = mb[k][j];
      end
      load_row(1'b1, k, d);
    end
  endtask

  task automatic test_stream();
    logic [N*DW-1:0] ea, eb;
    logic [N-1:0]    ev;
    load_tiles();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2*N-1; c++) begin
      ea = '0; eb = '0; ev = '0;
      for (int l = 0; l < N; l++) begin
        if (c - l >= 0 && c - l < N) begin
          ev[l] = 1'b1;
          ea[l*DW +: DW] = ma[l][c-l];
          eb[l*DW +: DW] = mb[c-l][l];
        end
      end
      total++;
      if (a_valid !== ev || a_data !== ea) begin
        bad++;
        $display("FAIL stream_a step %0d: av=%b ad=%h, required av=%b ad=%h", c, a_valid, a_data, ev, ea);
      end
      total++;
      if (b_valid !== ev || b_data !== eb) begin
        bad++;
        $display("FAIL stream_b step %0d: bv=%b bd=%h, required bv=%b bd=%h", c, b_valid, b_data, ev, eb);
      end
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || ld_ready !== 1'b0) begin
        bad++;
        $display("FAIL stream_ctrl step %0d: busy=%b done=%b rdy=%b, required 1/0/0", c, busy, done, ld_ready);
      end
      if (c == 0) begin
        total++;
        if (a_valid !== 4'b0001 || a_data[31:0] !== 32'h0 || b_valid !== 4'b0001 || b_data[31:0] !== 32'h100) begin
          bad++;
          $display("FAIL step0_hand: av=%b a0=%h bv=%b b0=%h, required 0001/0/0001/100",
                   a_valid, a_data[31:0], b_valid, b_data[31:0]);
        end
      end
      if (c == 3) begin
        total++;
        if (a_valid !== 4'b1111 || a_data !== {32'h30, 32'h21, 32'h12, 32'h03}) begin
          bad++;
          $display("FAIL step3_hand: av=%b ad=%h, required 1111 lanes 03,12,21,30", a_valid, a_data);
        end
      end
      if (c == 6) begin
        total++;
        if (a_valid !== 4'b1000 || a_data[127:96] !== 32'h33 || b_data[127:96] !== 32'h133) begin
          bad++;
          $display("FAIL step6_hand: av=%b a3=%h b3=%h, required 1000/33/133", a_valid, a_data[127:96], b_data[127:96]);
        end
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || a_valid !== '0 || b_valid !== '0) begin
      bad++;
      $display("FAIL stream_done: done=%b busy=%b av=%b bv=%b, required 1/0/0/0", done, busy, a_valid, b_valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_load_while_busy();
    start = 1'b1;
    tick();
    start = 1'b0;
    load_row(1'b0, 0, {N{32'hFF}});
    run_to_idle("busy_load");
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (a_valid !== 4'b0001 || a_data[31:0] !== ma[0][0]) begin
      bad++;
      $display("FAIL busy_load_ignored: av=%b a0=%h, required 0001/%h", a_valid, a_data[31:0], ma[0][0]);
    end
    run_to_idle("replay");
  endtask

  task automatic test_load_and_start();
    ld_en = 1'b1; ld_sel = 1'b0; ld_idx = 2'd2; ld_data = {N{32'hAAAAAAAA}};
    start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    for (int k = 0; k < N; k++) ma[2][k] = 32'hAAAAAAAA;
    tick(); tick();
    total++;
    if (a_valid !== 4'b0111 || a_data[95:64] !== 32'hAAAAAAAA || a_data[31:0] !== ma[0][2]) begin
      bad++;
      $display("FAIL load_and_start: av=%b a2=%h a0=%h, required 0111/aaaaaaaa/%h",
               a_valid, a_data[95:64], a_data[31:0], ma[0][2]);
    end
    run_to_idle("load_start");
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    int   dones = 0;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_busy = (n >= 1 && n <= 7) || (n >= 10 && n <= 16) || (n >= 19);
      exp_done = (n == 8) || (n == 17);
      if (done === 1'b1) dones++;
      total++;
      if (busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL back_to_back cycle t+%0d: busy=%b done=%b, required %b/%b", n, busy, done, exp_busy, exp_done);
      end
    end
    start = 1'b0;
    total++;
    if (dones != 2) begin
      bad++;
      $display("FAIL back_to_back_count: %0d done pulses, required 2", dones);
    end
    run_to_idle("b2b");
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, a_valid, b_valid} !== '0 || a_data !== '0 || b_data !== '0 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b av=%b bv=%b ad=%h bd=%h rdy=%b, required all 0 and rdy=1",
               busy, done, a_valid, b_valid, a_data, b_data, ld_ready);
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_quiet cycle %0d: done=%b busy=%b, required 0/0", n, done, busy);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2*N-1; c++) begin
      ev = '0;
      for (int l = 0; l < N; l++) if (c - l >= 0 && c - l < N) ev[l] = 1'b1;
      total++;
      if (a_valid !== ev || b_valid !== ev || a_data !== '0 || b_data !== '0) begin
        bad++;
        $display("FAIL reset_zero_stream step %0d: av=%b bv=%b ad=%h bd=%h, required av=bv=%b data 0",
                 c, a_valid, b_valid, a_data, b_data, ev);
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart_done: done=%b, required 1", done);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0;
    test_reset();
    test_stream();
    test_load_while_busy();
    test_load_and_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
